// File: rtl/rs_syndrome_calc.sv
// RS(255,239) syndrome calculator over GF(2^8), poly 0x11D: Horner accumulation of NSYM syndromes.
// Optional length checking (len_err output) is enabled with `define RS_LEN_CHECK_EN.
module rs_syndrome_calc #(
  parameter int N    = 255,
  parameter int NSYM = 16,
  parameter int FCR  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_sop,
  input  logic [7:0]        in_data,
  output logic              synd_valid,
  output logic [8*NSYM-1:0] synd,
  output logic              err_det,
`ifdef RS_LEN_CHECK_EN
  output logic              len_err,
`endif
  output logic              busy
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic {IDLE, ACCUM} state_t;

  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1D : 8'h00);
  endfunction

  // With b constant this unrolls into a fixed xor network.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] s;
    p = 8'h00;
    s = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ s;
      s = gf_xtime(s);
    end
    return p;
  endfunction

  function automatic logic [7:0] gf_pow(input int e);
    logic [7:0] p;
    p = 8'h01;
    for (int i = 0; i < (e % 255); i++) p = gf_xtime(p);
    return p;
  endfunction

  state_t                     state_q;
  logic [CW-1:0]              count_q, count_d;
  logic [NSYM-1:0][7:0]       acc_q, acc_d, mul;
  logic [NSYM-1:0][7:0]       synd_q;
  logic                       synd_valid_q;
  logic                       err_det_q;
  logic                       take, sym_last;

  for (genvar j = 0; j < NSYM; j++) begin : g_mul
    localparam logic [7:0] Root = gf_pow(FCR + j);
    assign mul[j] = gf_mul(acc_q[j], Root);
  end

  // An in_sop always (re)starts a codeword, even mid-accumulation.
  always_comb begin
    acc_d    = acc_q;
    count_d  = count_q;
    take     = 1'b0;
    sym_last = 1'b0;
    if (in_valid && (in_sop || state_q == ACCUM)) begin
      take    = 1'b1;
      count_d = in_sop ? CW'(1) : count_q + CW'(1);
      for (int j = 0; j < NSYM; j++) begin
        acc_d[j] = in_sop ? in_data : (mul[j] ^ in_data);
      end
      sym_last = (count_d == CW'(N));
    end
  end

  // Output register is loaded straight from the final accumulator value,
  // leaving the accumulators free for a back-to-back codeword.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      count_q      <= '0;
      acc_q        <= '0;
      synd_q       <= '0;
      synd_valid_q <= 1'b0;
      err_det_q    <= 1'b0;
    end else begin
      synd_valid_q <= 1'b0;
      if (take) begin
        acc_q <= acc_d;
        if (sym_last) begin
          state_q      <= IDLE;
          count_q      <= '0;
          synd_q       <= acc_d;
          err_det_q    <= |acc_d;
          synd_valid_q <= 1'b1;
        end else begin
          state_q <= ACCUM;
          count_q <= count_d;
        end
      end
    end
  end

  assign synd    = synd_q;
  assign err_det = err_det_q;
  assign busy    = (state_q == ACCUM);

`ifdef RS_LEN_CHECK_EN
  logic overlong;
  // Extra data right after a codeword end means it was longer than N.
  assign overlong   = in_valid && !in_sop && (state_q == IDLE) && synd_valid_q;
  assign len_err    = (in_valid && in_sop && (state_q == ACCUM)) || overlong;
  assign synd_valid = synd_valid_q && !overlong;
`else
  assign synd_valid = synd_valid_q;
`endif

endmodule

// File: tb/tb_rs_syndrome_calc.sv
// Scoreboard bench for rs_syndrome_calc: directed codewords with hand-computed syndromes.
module tb_rs_syndrome_calc;

  localparam int N    = 255;
  localparam int NSYM = 16;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                inValid = 1'b0;
  logic                inSop = 1'b0;
  logic [7:0]          inData = 8'h00;
  logic                syndValid;
  logic [8*NSYM-1:0]   synd;
  logic                errDet;
  logic                busy;

  rs_syndrome_calc #(.N(N), .NSYM(NSYM), .FCR(0)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (inValid),
    .in_sop     (inSop),
    .in_data    (inData),
    .synd_valid (syndValid),
    .synd       (synd),
    .err_det    (errDet),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] synd;
    logic         err;
    int           cyc;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // alpha^j and alpha^(2j), j = 0..15
  logic [7:0] alpha1 [16] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                              8'h1D, 8'h3A, 8'h74, 8'hE8, 8'hCD, 8'h87, 8'h13, 8'h26};
  logic [7:0] alpha2 [16] = '{8'h01, 8'h04, 8'h10, 8'h40, 8'h1D, 8'h74, 8'hCD, 8'h13,
                              8'h4C, 8'h2D, 8'hB4, 8'hEA, 8'h8F, 8'h06, 8'h18, 8'h60};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [127:0] packSyn(input logic [7:0] b [16]);
    logic [127:0] r;
    for (int j = 0; j < 16; j++) r[8*j +: 8] = b[j];
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: every synd_valid pulse must match the next scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && syndValid === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_synd_valid: got pulse at cycle %0d expected none", cyc);
      end else begin
        e = sbq.pop_front();
        checkOutput("synd", synd, e.synd);
        checkOutput("err_det", 128'(errDet), 128'(e.err));
        checkOutput("latency", 128'(cyc), 128'(e.cyc));
      end
    end
  end

  task automatic applyStimulus(input logic v, input logic s, input logic [7:0] d);
    inValid = v;
    inSop   = s;
    inData  = d;
    @(posedge clk);
    #1;
  endtask

  // Zero codeword with up to two symbols overridden (positions counted from the end, 0 = last).
  task automatic sendCw(input int p0, input logic [7:0] v0, input int p1, input logic [7:0] v1,
                        input bit gapped, input logic [127:0] es, input logic ee);
    for (int i = 0; i < N; i++) begin
      automatic logic [7:0] d = 8'h00;
      if (N - 1 - i == p0) d = d ^ v0;
      if (N - 1 - i == p1) d = d ^ v1;
      if (i == N - 1) sbq.push_back('{es, ee, cyc + 1});
      applyStimulus(1'b1, i == 0, d);
      if (gapped && i != N - 1) applyStimulus(1'b0, 1'b0, 8'h5A);
    end
  endtask

  task automatic sendPartial(input int n, input logic [7:0] d);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, i == 0, d);
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 8'h00);
  endtask

  logic [127:0] rep05, synA1, synA2, synMix;

  initial begin
    rep05  = {16{8'h05}};
    synA1  = packSyn(alpha1);
    synA2  = packSyn(alpha2);
    synMix = rep05 ^ synA1;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_synd", synd, 128'h0);
    checkOutput("reset_err_det", 128'(errDet), 128'h0);
    checkOutput("reset_busy", 128'(busy), 128'h0);
    checkOutput("reset_synd_valid", 128'(syndValid), 128'h0);
    rst = 1'b0;

    $display("[TB] data without sop in IDLE is ignored");
    repeat (3) applyStimulus(1'b1, 1'b0, 8'hAA);
    checkOutput("idle_ignore_busy", 128'(busy), 128'h0);
    idle(2);

    $display("[TB] all-zero codeword");
    sendCw(-1, 8'h00, -1, 8'h00, 1'b0, 128'h0, 1'b0);
    idle(3);
    checkOutput("post_cw_busy", 128'(busy), 128'h0);

    $display("[TB] three back-to-back codewords");
    sendCw(0, 8'h05, -1, 8'h00, 1'b0, rep05, 1'b1);
    sendCw(1, 8'h01, -1, 8'h00, 1'b0, synA1, 1'b1);
    sendCw(0, 8'h05, 1, 8'h01, 1'b0, synMix, 1'b1);
    idle(5);
    checkOutput("hold_synd", synd, synMix);
    checkOutput("hold_err_det", 128'(errDet), 128'h1);

    $display("[TB] gapped input");
    sendCw(0, 8'h05, -1, 8'h00, 1'b1, rep05, 1'b1);
    idle(2);

    $display("[TB] error at third-to-last position");
    sendCw(2, 8'h01, -1, 8'h00, 1'b0, synA2, 1'b1);
    idle(2);

    $display("[TB] reset mid-codeword");
    sendPartial(100, 8'hFF);
    checkOutput("mid_cw_busy", 128'(busy), 128'h1);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'h00);
    rst = 1'b0;
    checkOutput("midrst_synd", synd, 128'h0);
    checkOutput("midrst_err_det", 128'(errDet), 128'h0);
    checkOutput("midrst_busy", 128'(busy), 128'h0);
    sendCw(1, 8'h01, -1, 8'h00, 1'b0, synA1, 1'b1);
    idle(2);

    $display("[TB] early restart");
    sendPartial(50, 8'h33);
    sendCw(0, 8'h05, -1, 8'h00, 1'b0, rep05, 1'b1);
    idle(2);

    for (int t = 0; t < 20 && sbq.size() != 0; t++) @(posedge clk);
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL timeout: got %0d outstanding results expected 0", sbq.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
    $finish;
  end

endmodule
